// File: rtl/irrigation_pkg.sv
// Shared types and default timing constants for the irrigation valve sequencer.
package irrigation_pkg;

    typedef enum logic [2:0] {
        LOCKOUT  = 3'd0,
        IDLE     = 3'd1,
        ASP_ON   = 3'd2,
        GOT_ON   = 3'd3,
        COOLDOWN = 3'd4
    } state_t;

    localparam int DEF_CNT_W              = 16;
    localparam int DEF_MIN_ON_CYCLES      = 1000;
    localparam int DEF_MAX_ON_CYCLES      = 60000;
    localparam int DEF_COOLDOWN_CYCLES    = 500;
    localparam int DEF_FAULT_CLEAR_CYCLES = 256;

    function automatic logic is_busy(input state_t s);
        return (s == ASP_ON) || (s == GOT_ON) || (s == COOLDOWN);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs, cleared by the async reset.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/irrigation_sequencer.sv
// Timed valve sequencer: synchronised requests drive a mutually exclusive
// sprinkler/drip FSM with min-on, max-on, cooldown and fault-lockout timing.
module irrigation_sequencer
    import irrigation_pkg::*;
#(
    parameter int CNT_W              = DEF_CNT_W,
    parameter int MIN_ON_CYCLES      = DEF_MIN_ON_CYCLES,
    parameter int MAX_ON_CYCLES      = DEF_MAX_ON_CYCLES,
    parameter int COOLDOWN_CYCLES    = DEF_COOLDOWN_CYCLES,
    parameter int FAULT_CLEAR_CYCLES = DEF_FAULT_CLEAR_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       erro_in,
    input  logic       alarme_in,
    input  logic       ve_req,
    input  logic       asp_req,
    input  logic       got_req,
    output logic       valve_ent,
    output logic       valve_asp,
    output logic       valve_got,
    output logic       busy,
    output logic       fault_lock,
    output logic       timeout,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] MIN_LAST   = CNT_W'(MIN_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_LAST   = CNT_W'(MAX_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] FAULT_LAST = CNT_W'(FAULT_CLEAR_CYCLES - 1);

    logic [4:0] sync_q;
    logic       erro_s, alarme_s, ve_req_s, asp_req_s, got_req_s;
    logic       fault_s, own_req;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             timeout_next;
    logic             valve_ent_next, valve_asp_next, valve_got_next;
    logic             busy_next, fault_lock_next;

    sync2 #(.W(5)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({erro_in, alarme_in, ve_req, asp_req, got_req}),
        .q     (sync_q)
    );

    assign {erro_s, alarme_s, ve_req_s, asp_req_s, got_req_s} = sync_q;
    assign fault_s = erro_s | alarme_s;
    assign own_req = (state == ASP_ON) ? asp_req_s : got_req_s;

    // State, counter and Moore output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOCKOUT;
            cnt        <= '0;
            valve_ent  <= 1'b0;
            valve_asp  <= 1'b0;
            valve_got  <= 1'b0;
            busy       <= 1'b0;
            fault_lock <= 1'b1;
            timeout    <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            valve_ent  <= valve_ent_next;
            valve_asp  <= valve_asp_next;
            valve_got  <= valve_got_next;
            busy       <= busy_next;
            fault_lock <= fault_lock_next;
            timeout    <= timeout_next;
        end
    end

    // Next state; fault beats everything, and max-on beats the min-on release.
    always_comb begin
        state_next   = state;
        timeout_next = 1'b0;
        case (state)
            LOCKOUT: begin
                if (!fault_s && cnt == FAULT_LAST) state_next = IDLE;
            end
            IDLE: begin
                if (fault_s)        state_next = LOCKOUT;
                else if (asp_req_s) state_next = ASP_ON;
                else if (got_req_s) state_next = GOT_ON;
            end
            ASP_ON, GOT_ON: begin
                if (fault_s) begin
                    state_next = LOCKOUT;
                end else if (cnt == MAX_LAST) begin
                    state_next   = COOLDOWN;
                    timeout_next = 1'b1;
                end else if (!own_req && cnt >= MIN_LAST) begin
                    state_next = COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (fault_s)               state_next = LOCKOUT;
                else if (cnt == COOL_LAST) state_next = IDLE;
            end
            default: state_next = LOCKOUT;
        endcase

        // Any fault cycle in lockout restarts the clean-cycle count.
        if (state_next != state)             cnt_next = '0;
        else if (state == LOCKOUT && fault_s) cnt_next = '0;
        else if (cnt != '1)                  cnt_next = cnt + 1'b1;
        else                                 cnt_next = cnt;
    end

    always_comb begin
        valve_asp_next  = (state_next == ASP_ON);
        valve_got_next  = (state_next == GOT_ON);
        busy_next       = is_busy(state_next);
        fault_lock_next = (state_next == LOCKOUT);
        // Inlet refill is allowed under alarm; only a sensor error blocks it.
        valve_ent_next  = ve_req_s & ~erro_s;
    end

    assign state_o = state;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed self-checking bench for irrigation_sequencer with shortened timing.
module tb_irrigation_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       erro_in = 1'b0;
    logic       alarme_in = 1'b0;
    logic       ve_req = 1'b0;
    logic       asp_req = 1'b0;
    logic       got_req = 1'b0;
    logic       valve_ent, valve_asp, valve_got, busy, fault_lock, timeout;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    irrigation_sequencer #(
        .CNT_W              (16),
        .MIN_ON_CYCLES      (4),
        .MAX_ON_CYCLES      (10),
        .COOLDOWN_CYCLES    (3),
        .FAULT_CLEAR_CYCLES (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .erro_in    (erro_in),
        .alarme_in  (alarme_in),
        .ve_req     (ve_req),
        .asp_req    (asp_req),
        .got_req    (got_req),
        .valve_ent  (valve_ent),
        .valve_asp  (valve_asp),
        .valve_got  (valve_got),
        .busy       (busy),
        .fault_lock (fault_lock),
        .timeout    (timeout),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        int n = 0;
        while (state_o !== s && n < budget) begin
            step();
            n++;
        end
        check(tag, {29'd0, state_o}, {29'd0, s});
    endtask

    task automatic pulse_asp();
        asp_req = 1'b1;
        step();
        asp_req = 1'b0;
    endtask

    initial begin
        // reset values
        step(); step();
        check("rst_state", {29'd0, state_o}, 32'd0);
        check("rst_lock", {31'd0, fault_lock}, 32'd1);
        check("rst_valves", {29'd0, valve_ent, valve_asp, valve_got}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);

        // release: five lockout cycles, then IDLE
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("boot_lock", {31'd0, fault_lock}, 32'd1);
            check("boot_valves", {30'd0, valve_asp, valve_got}, 32'd0);
        end
        step();
        check("boot_idle", {29'd0, state_o}, 32'd1);
        check("boot_unlock", {31'd0, fault_lock}, 32'd0);

        // one-cycle sprinkler request: 4 on, 3 cooldown
        pulse_asp();
        step();
        check("asp_latency", {31'd0, valve_asp}, 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            check("asp_on", {31'd0, valve_asp}, 32'd1);
            check("asp_busy", {31'd0, busy}, 32'd1);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            check("asp_cool_valve", {31'd0, valve_asp}, 32'd0);
            check("asp_cool_busy", {31'd0, busy}, 32'd1);
            check("asp_cool_state", {29'd0, state_o}, 32'd4);
            step();
        end
        check("asp_idle", {29'd0, state_o}, 32'd1);
        check("asp_idle_busy", {31'd0, busy}, 32'd0);

        // held drip request: max-on timeout, cooldown, then on again
        got_req = 1'b1;
        step(); step();
        check("got_latency", {31'd0, valve_got}, 32'd0);
        step();
        for (int i = 0; i < 10; i++) begin
            check("got_on", {31'd0, valve_got}, 32'd1);
            check("got_no_timeout", {31'd0, timeout}, 32'd0);
            step();
        end
        check("got_timeout", {31'd0, timeout}, 32'd1);
        check("got_off", {31'd0, valve_got}, 32'd0);
        check("got_cool", {29'd0, state_o}, 32'd4);
        step();
        check("got_timeout_pulse", {31'd0, timeout}, 32'd0);
        step(); step();
        check("got_cool_idle", {29'd0, state_o}, 32'd1);
        step();
        check("got_again", {29'd0, state_o}, 32'd3);
        check("got_again_valve", {31'd0, valve_got}, 32'd1);
        got_req = 1'b0;
        wait_state("got_release", 3'd1, 20);

        // simultaneous requests: sprinkler wins
        asp_req = 1'b1;
        got_req = 1'b1;
        step();
        asp_req = 1'b0;
        got_req = 1'b0;
        step(); step();
        for (int i = 0; i < 4; i++) begin
            check("both_asp", {31'd0, valve_asp}, 32'd1);
            check("both_got", {31'd0, valve_got}, 32'd0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            check("both_cool_got", {31'd0, valve_got}, 32'd0);
            step();
        end
        check("both_idle", {29'd0, state_o}, 32'd1);

        // error during ASP_ON, then a glitch restarts the clear count
        pulse_asp();
        step(); step();
        check("flt_pre", {31'd0, valve_asp}, 32'd1);
        erro_in = 1'b1;
        step();
        check("flt_lat1", {31'd0, valve_asp}, 32'd1);
        step();
        check("flt_lat2", {31'd0, valve_asp}, 32'd1);
        step();
        check("flt_off", {31'd0, valve_asp}, 32'd0);
        check("flt_lock", {31'd0, fault_lock}, 32'd1);
        check("flt_state", {29'd0, state_o}, 32'd0);
        erro_in = 1'b0;
        step(); step(); step();
        erro_in = 1'b1;
        step();
        erro_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("flt_restart", {31'd0, fault_lock}, 32'd1);
        end
        step();
        check("flt_clear", {29'd0, state_o}, 32'd1);

        // inlet refill continues under alarm, stops on error
        ve_req = 1'b1;
        alarme_in = 1'b1;
        step();
        check("ent_latency", {31'd0, valve_ent}, 32'd0);
        step(); step();
        check("ent_alarm", {31'd0, valve_ent}, 32'd1);
        check("ent_alarm_lock", {31'd0, fault_lock}, 32'd1);
        step();
        erro_in = 1'b1;
        step();
        check("ent_err_lat1", {31'd0, valve_ent}, 32'd1);
        step();
        check("ent_err_lat2", {31'd0, valve_ent}, 32'd1);
        step();
        check("ent_err_off", {31'd0, valve_ent}, 32'd0);

        // reset mid-run drops valves asynchronously
        erro_in = 1'b0;
        alarme_in = 1'b0;
        wait_state("rst_relock", 3'd1, 30);
        pulse_asp();
        step(); step();
        check("mid_pre_asp", {31'd0, valve_asp}, 32'd1);
        check("mid_pre_ent", {31'd0, valve_ent}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_asp", {31'd0, valve_asp}, 32'd0);
        check("mid_ent", {31'd0, valve_ent}, 32'd0);
        check("mid_lock", {31'd0, fault_lock}, 32'd1);
        check("mid_state", {29'd0, state_o}, 32'd0);
        step();
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
